// File: rtl/sa_cache_4way_pkg.sv
// Shared geometry, state encoding and helpers for the 4-way set-associative cache.
package sa_cache_4way_pkg;

    localparam int TAG_W  = 18;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 6;
    localparam int WAYS   = 4;
    localparam int SETS   = 256;
    localparam int LINE_W = 32;
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef logic [1:0] way_t;

    // Lowest-numbered way whose valid bit is clear; 0 when every way is valid.
    function automatic way_t first_invalid(input logic [WAYS-1:0] valid);
        way_t r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                r = way_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sa_plru4.sv
// 3-bit tree pseudo-LRU for one 4-way set: victim selection and access update.
// Bit 0 picks the half (0 = ways 0/1, 1 = ways 2/3); bits 1 and 2 pick within each half.
module sa_plru4 (
    input  logic [2:0] plru_state,
    input  logic [1:0] access_way,
    output logic [1:0] victim,
    output logic [2:0] next_state
);

    // Follow the tree bits down to the least recently used way.
    always_comb begin
        victim = 2'd0;
        if (!plru_state[0]) begin
            victim = {1'b0, plru_state[1]};
        end else begin
            victim = {1'b1, plru_state[2]};
        end
    end

    // Point the root away from the accessed half and the leaf away from the accessed way.
    always_comb begin
        next_state = plru_state;
        if (!access_way[1]) begin
            next_state[0] = 1'b1;
            next_state[1] = ~access_way[0];
        end else begin
            next_state[0] = 1'b0;
            next_state[2] = ~access_way[0];
        end
    end

endmodule

// File: rtl/sa_cache_4way.sv
// 4-way set-associative write-back, write-allocate cache with one 32-bit word per line.
// Lookup is combinational; misses optionally evict one dirty line, then wait for a fill.
module sa_cache_4way
    import sa_cache_4way_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [LINE_W-1:0] dataW,
    input  logic              memRW,
    input  logic [LINE_W-1:0] i_memory_line,
    input  logic              i_memory_response,
    output logic [LINE_W-1:0] o_data,
    output logic [LINE_W-1:0] line_data,
    output logic              cache_miss,
    output logic [LINE_W-1:0] o_evict_data,
    output logic [ADDR_W-1:0] o_evict_addr,
    output logic              o_evict
);

    state_t state;
    state_t state_next;

    logic [SETS-1:0][WAYS-1:0] valid_mem;
    logic [SETS-1:0][WAYS-1:0] dirty_mem;
    logic [SETS-1:0][2:0]      plru_mem;
    logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0]         data_mem [SETS][WAYS];

    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_index;
    logic              lat_rw;
    logic [LINE_W-1:0] lat_data;
    way_t              lat_way;

    logic [WAYS-1:0] set_valid;
    logic [WAYS-1:0] set_dirty;
    logic            hit;
    way_t            hit_way;
    way_t            victim_way;
    way_t            plru_victim;
    logic            victim_dirty;
    logic [IDX_W-1:0] plru_index;
    way_t            plru_access;
    logic [2:0]      plru_next;
    logic            hit_fire;
    logic            miss_start;
    logic            fill_fire;
    logic            offset_unused;

    // The byte offset never selects data since each line holds a single word.
    assign offset_unused = ^i_offset;

    assign set_valid = valid_mem[i_index];
    assign set_dirty = dirty_mem[i_index];

    // Tag compare across the addressed set; at most one way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && (tag_mem[i_index][w] == i_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    assign line_data = hit ? data_mem[i_index][hit_way] : '0;

    // In IDLE the PLRU tree of the requested set is consulted; during a fill, the latched set.
    assign plru_index  = (state == IDLE) ? i_index : lat_index;
    assign plru_access = (state == IDLE) ? hit_way : lat_way;

    sa_plru4 u_plru (
        .plru_state (plru_mem[plru_index]),
        .access_way (plru_access),
        .victim     (plru_victim),
        .next_state (plru_next)
    );

    assign victim_way   = (&set_valid) ? plru_victim : first_invalid(set_valid);
    assign victim_dirty = set_valid[victim_way] && set_dirty[victim_way];

    assign hit_fire   = (state == IDLE) && hit;
    assign miss_start = (state == IDLE) && !hit;
    assign fill_fire  = (state == FILL) && i_memory_response;

    // Next-state logic for the miss handler, plus the miss indication to the requester.
    always_comb begin
        state_next = state;
        cache_miss = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    cache_miss = 1'b1;
                    state_next = victim_dirty ? EVICT : FILL;
                end
            end
            EVICT: begin
                cache_miss = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                cache_miss = 1'b1;
                if (i_memory_response) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cache_miss = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any miss in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the missing request and its chosen victim way for the fill.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            lat_tag   <= i_tag;
            lat_index <= i_index;
            lat_rw    <= memRW;
            lat_data  <= dataW;
            lat_way   <= victim_way;
        end
    end

    // Eviction strobe lasts exactly the EVICT cycle; victim data and address hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_evict      <= 1'b0;
            o_evict_data <= '0;
            o_evict_addr <= '0;
        end else begin
            o_evict <= miss_start && victim_dirty;
            if (miss_start && victim_dirty) begin
                o_evict_data <= data_mem[i_index][victim_way];
                o_evict_addr <= {tag_mem[i_index][victim_way], i_index, {OFF_W{1'b0}}};
            end
        end
    end

    // Registered read result from a read hit or from the fill line of a read miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
        end else if (hit_fire && !memRW) begin
            o_data <= data_mem[i_index][hit_way];
        end else if (fill_fire && !lat_rw) begin
            o_data <= i_memory_line;
        end
    end

    // Valid, dirty and PLRU bookkeeping for hits and completed fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mem <= '0;
            dirty_mem <= '0;
            plru_mem  <= '0;
        end else if (hit_fire) begin
            plru_mem[i_index] <= plru_next;
            if (memRW) begin
                dirty_mem[i_index][hit_way] <= 1'b1;
            end
        end else if (fill_fire) begin
            valid_mem[lat_index][lat_way] <= 1'b1;
            dirty_mem[lat_index][lat_way] <= lat_rw;
            plru_mem[lat_index]           <= plru_next;
        end
    end

    // Tag and data arrays carry no reset; they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_fire && memRW) begin
                data_mem[i_index][hit_way] <= dataW;
            end
            if (fill_fire) begin
                tag_mem[lat_index][lat_way]  <= lat_tag;
                data_mem[lat_index][lat_way] <= lat_rw ? lat_data : i_memory_line;
            end
        end
    end

endmodule

// File: tb/tb_sa_cache_4way.sv
// Self-checking bench for sa_cache_4way: a table of accesses to set 5/6 with expected
// miss/evict/data behaviour, a read-data scoreboard, and hand-written reset/strobe sequences.
module tb_sa_cache_4way;

    logic        clk;
    logic        rst;
    logic [17:0] i_tag;
    logic [7:0]  i_index;
    logic [5:0]  i_offset;
    logic [31:0] dataW;
    logic        memRW;
    logic [31:0] i_memory_line;
    logic        i_memory_response;
    logic [31:0] o_data;
    logic [31:0] line_data;
    logic        cache_miss;
    logic [31:0] o_evict_data;
    logic [31:0] o_evict_addr;
    logic        o_evict;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [17:0] tag;
        logic [7:0]  idx;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] fill;
        logic        exp_miss;
        logic        exp_evict;
        logic [31:0] exp_eaddr;
        logic [31:0] exp_edata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    sa_cache_4way dut (
        .clk               (clk),
        .rst               (rst),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_offset          (i_offset),
        .dataW             (dataW),
        .memRW             (memRW),
        .i_memory_line     (i_memory_line),
        .i_memory_response (i_memory_response),
        .o_data            (o_data),
        .line_data         (line_data),
        .cache_miss        (cache_miss),
        .o_evict_data      (o_evict_data),
        .o_evict_addr      (o_evict_addr),
        .o_evict           (o_evict)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string name, input logic [17:0] tag, input logic [7:0] idx,
                                input logic rw, input logic [31:0] wdata, input logic [31:0] fill,
                                input logic exp_miss, input logic exp_evict,
                                input logic [31:0] exp_eaddr, input logic [31:0] exp_edata,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.name      = name;
        v.tag       = tag;
        v.idx       = idx;
        v.rw        = rw;
        v.wdata     = wdata;
        v.fill      = fill;
        v.exp_miss  = exp_miss;
        v.exp_evict = exp_evict;
        v.exp_eaddr = exp_eaddr;
        v.exp_edata = exp_edata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_tag    = v.tag;
        i_index  = v.idx;
        memRW    = v.rw;
        dataW    = v.wdata;
        i_offset = 6'($urandom);
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] expected;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s_sb: got %h expected an entry in the scoreboard", name, o_data);
        end else begin
            expected = exp_q.pop_front();
            if (o_data !== expected) begin
                bad++;
                $display("[TB] FAIL %s_o_data: got %h expected %h", name, o_data, expected);
            end
        end
    endtask

    // One full request: hit path or miss -> (evict) -> fill -> hit.
    task automatic run_vector(input vec_t v);
        applyStimulus(v);
        #1;
        check({v.name, "_miss"}, {31'd0, cache_miss}, {31'd0, v.exp_miss});
        if (!v.exp_miss) begin
            if (!v.rw) begin
                check({v.name, "_line"}, line_data, v.exp_rdata);
                exp_q.push_back(v.exp_rdata);
            end
            tick();
            if (!v.rw) checkOutput(v.name);
        end else begin
            tick();
            check({v.name, "_evict"}, {31'd0, o_evict}, {31'd0, v.exp_evict});
            if (v.exp_evict) begin
                check({v.name, "_eaddr"}, o_evict_addr, v.exp_eaddr);
                check({v.name, "_edata"}, o_evict_data, v.exp_edata);
                tick();
                check({v.name, "_evict_drop"}, {31'd0, o_evict}, 32'd0);
                check({v.name, "_eaddr_hold"}, o_evict_addr, v.exp_eaddr);
            end
            check({v.name, "_fill_wait"}, {31'd0, cache_miss}, 32'd1);
            tick();
            check({v.name, "_fill_wait2"}, {31'd0, cache_miss}, 32'd1);
            i_memory_line     = v.fill;
            i_memory_response = 1'b1;
            if (!v.rw) exp_q.push_back(v.fill);
            tick();
            i_memory_response = 1'b0;
            i_memory_line     = 32'h0;
            #1;
            check({v.name, "_after_fill"}, {31'd0, cache_miss}, 32'd0);
            if (!v.rw) checkOutput(v.name);
            tick();
        end
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        rst               = 1'b1;
        i_tag             = '0;
        i_index           = '0;
        i_offset          = '0;
        dataW             = '0;
        memRW             = 1'b0;
        i_memory_line     = '0;
        i_memory_response = 1'b0;

        vecs.push_back(mk("rd_t1_miss",  18'h1, 8'h05, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("rd_t1_hit",   18'h1, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("wr_t2_miss",  18'h2, 8'h05, 1'b1, 32'h12345678, 32'hAAAAAAAA, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("rd_t2_hit",   18'h2, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h12345678));
        vecs.push_back(mk("rd_t3_miss",  18'h3, 8'h05, 1'b0, 32'h0,        32'h33333333, 1'b1, 1'b0, 32'h0,        32'h0,        32'h33333333));
        vecs.push_back(mk("rd_t4_miss",  18'h4, 8'h05, 1'b0, 32'h0,        32'h44444444, 1'b1, 1'b0, 32'h0,        32'h0,        32'h44444444));
        vecs.push_back(mk("touch_t1",    18'h1, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF));
        vecs.push_back(mk("touch_t3",    18'h3, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h33333333));
        vecs.push_back(mk("touch_t4",    18'h4, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h44444444));
        vecs.push_back(mk("rd_t5_evict", 18'h5, 8'h05, 1'b0, 32'h0,        32'h55555555, 1'b1, 1'b1, {18'h2, 8'h05, 6'h0}, 32'h12345678, 32'h55555555));
        vecs.push_back(mk("rd_t5_hit",   18'h5, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h55555555));
        vecs.push_back(mk("rd_t2_clean", 18'h2, 8'h05, 1'b0, 32'h0,        32'h22222222, 1'b1, 1'b0, 32'h0,        32'h0,        32'h22222222));
        vecs.push_back(mk("rd_t3_clean", 18'h3, 8'h05, 1'b0, 32'h0,        32'h3333AAAA, 1'b1, 1'b0, 32'h0,        32'h0,        32'h3333AAAA));
        vecs.push_back(mk("wr_t7_set6",  18'h7, 8'h06, 1'b1, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("rd_t7_set6",  18'h7, 8'h06, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D));
        vecs.push_back(mk("wr_t5_hit",   18'h5, 8'h05, 1'b1, 32'h0BADF00D, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk("rd_t5_new",   18'h5, 8'h05, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0BADF00D));

        tick();
        tick();
        rst = 1'b0;

        // Reset state with a first request already presented.
        applyStimulus(vecs[0]);
        #1;
        check("rst_o_data", o_data, 32'h0);
        check("rst_o_evict", {31'd0, o_evict}, 32'd0);
        check("rst_evict_addr", o_evict_addr, 32'h0);
        check("rst_evict_data", o_evict_data, 32'h0);
        check("rst_line_data", line_data, 32'h0);

        foreach (vecs[i]) begin
            run_vector(vecs[i]);
        end

        // Fill strobe held high while idle with a hitting request: nothing moves.
        i_memory_response = 1'b1;
        i_memory_line     = 32'hFFFFFFFF;
        applyStimulus(vecs[14]);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("idle_resp_miss", {31'd0, cache_miss}, 32'd0);
            check("idle_resp_line", line_data, 32'hCAFEF00D);
            tick();
            check("idle_resp_o_data", o_data, 32'hCAFEF00D);
        end
        i_memory_response = 1'b0;
        i_memory_line     = 32'h0;

        // Reset during FILL: miss on a new tag, then reset with the response asserted.
        applyStimulus(mk("rd_t9", 18'h9, 8'h05, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
        #1;
        check("t9_miss", {31'd0, cache_miss}, 32'd1);
        tick();
        check("t9_fill", {31'd0, cache_miss}, 32'd1);
        check("t9_no_evict", {31'd0, o_evict}, 32'd0);
        rst               = 1'b1;
        i_memory_response = 1'b1;
        i_memory_line     = 32'h99999999;
        tick();
        rst               = 1'b0;
        i_memory_response = 1'b0;
        i_memory_line     = 32'h0;
        check("mid_rst_o_data", o_data, 32'h0);
        check("mid_rst_evict_addr", o_evict_addr, 32'h0);
        check("mid_rst_evict_data", o_evict_data, 32'h0);
        check("mid_rst_o_evict", {31'd0, o_evict}, 32'd0);
        applyStimulus(vecs[16]);
        #1;
        check("post_rst_t5_miss", {31'd0, cache_miss}, 32'd1);
        check("post_rst_t5_line", line_data, 32'h0);
        applyStimulus(vecs[14]);
        #1;
        check("post_rst_t7_miss", {31'd0, cache_miss}, 32'd1);
        tick();
        check("post_rst_fill_state", {31'd0, cache_miss}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sa_cache_4way.md
# sa_cache_4way

4-way set-associative, write-back, write-allocate data cache with 256 sets of one 32-bit word per line. It sits between a requester that presents a pre-split address (tag/index/offset) and a backing memory that returns fill lines and accepts evictions. Lookup is combinational. Misses run a small FSM that can evict one dirty line and then waits for a memory fill.

## Interface
- No parameters. Geometry is fixed: 4 ways, 256 sets, 18-bit tag, 32-bit line.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_tag  in  18  request tag (address[31:14]).
- i_index  in  8  set select (address[13:6]).
- i_offset  in  6  byte offset (address[5:0]); ignored for data select.
- dataW  in  32  write data.
- memRW  in  1  0 = read, 1 = write.
- i_memory_line  in  32  fill data from memory.
- i_memory_response  in  1  fill-valid strobe; sampled only in FILL.
- o_data  out  32  registered read result.
- line_data  out  32  combinational data of the hitting way; 0 on miss.
- cache_miss  out  1  high while the current request is not serviced.
- o_evict_data  out  32  dirty victim data.
- o_evict_addr  out  32  victim address {victim_tag, index, 6'b0}.
- o_evict  out  1  one-cycle eviction strobe.

## Operation
- Per set: 4 × {valid, dirty, tag[17:0], data[31:0]}, plus 3-bit tree pseudo-LRU (plru[0] selects the half, plru[1]/plru[2] select within each half).
- Every cycle in IDLE is a request. The requester must hold i_tag, i_index, dataW and memRW stable until cache_miss is low.
- Hit means some way w in the set has valid && tag == i_tag. At most one way can match.
- Read hit: o_data <= data[w]. PLRU is updated to point away from w.
- Write hit: data[w] <= dataW, dirty[w] <= 1, PLRU is updated.
- Miss in IDLE:
  - Latch tag, index, memRW and dataW.
  - Pick the victim: the lowest-numbered invalid way, otherwise the PLRU way.
  - If the victim is valid and dirty, go to EVICT; otherwise go to FILL.
- EVICT (1 cycle): o_evict = 1, o_evict_data = victim data, o_evict_addr = victim address. Then go to FILL.
- FILL: wait for i_memory_response = 1. On that edge:
  - tag <= latched tag, valid <= 1, PLRU is updated.
  - Read: data <= i_memory_line, dirty <= 0, o_data <= i_memory_line.
  - Write: data <= latched dataW, dirty <= 1.
  - Return to IDLE.
- cache_miss = (IDLE && !hit) || EVICT || FILL.

## Timing
- Reset (synchronous) clears all valid, dirty and PLRU bits and sets FSM = IDLE, o_data = 0, o_evict = 0, o_evict_data = 0, o_evict_addr = 0. Data and tag arrays need no reset.
- Reset asserted mid-miss aborts to IDLE. No eviction or fill is applied.
- Hit: cache_miss low in the same cycle. o_data is valid after the next edge.
- Clean miss, request at cycle 0: FILL from cycle 1. A response at cycle k ≥ 1 gives IDLE and hit at cycle k+1.
- Dirty miss: EVICT at cycle 1 (o_evict high for exactly that cycle), FILL from cycle 2.
- i_memory_response is ignored outside FILL.
- o_evict_data and o_evict_addr hold their last value when o_evict = 0.

## Structure
- Shared package holds: TAG_W = 18, IDX_W = 8, OFF_W = 6, WAYS = 4, SETS = 256, and the state enum {IDLE, EVICT, FILL}.
- One natural sub-module, sa_plru4: 3-bit tree PLRU victim selection and update.

## Test plan
- Reset, then read tag 0x00001 index 0x05 → cache_miss = 1, no o_evict. Response with line 0xDEADBEEF → o_data = 0xDEADBEEF, cache_miss = 0 next cycle.
- Re-read the same address → hit the same cycle. line_data = 0xDEADBEEF, o_data = 0xDEADBEEF.
- Write 0x12345678 to tag 0x00002 index 0x05 (miss), give the fill response, then read it → 0x12345678. The line is dirty.
- Fill ways with tags 1–4 in set 5 (tag 2 dirty). Touch 1, 3, 4, then access tag 5 → o_evict for one cycle, o_evict_addr = {18'h2, 8'h05, 6'h0}, o_evict_data = 0x12345678.
- Hold i_memory_response high in IDLE → no state change. Assert rst during FILL → IDLE, all lines invalid, outputs 0.
- A read miss to a clean victim → FILL entered directly, o_evict stays 0.
